hazard_ctrl: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller states and the width of the LSU busy-cycle counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MEMWAIT = 1'b1
  } hz_state_e;

  localparam int unsigned BUSY_W = 16;

  // The EX/MEM result is younger than the MEM/WB one, so it takes precedence.
  function automatic fwd_sel_e fwd_pick(logic exmem_hit, logic memwb_hit);
    if (exmem_hit) return FWD_EXMEM;
    if (memwb_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register fields into the hazard controller and its stage controls out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] i_ifid_rs1;
  logic [REG_AW-1:0] i_ifid_rs2;
  logic              i_ifid_rs1_used;
  logic              i_ifid_rs2_used;
  logic [REG_AW-1:0] i_idex_rd;
  logic              i_idex_rdwren;
  logic              i_idex_is_load;
  logic [REG_AW-1:0] i_exmem_rd;
  logic              i_exmem_rdwren;
  logic [REG_AW-1:0] i_memwb_rd;
  logic              i_memwb_rdwren;
  logic              i_exmem_redirect;
  logic              i_lsu_busy;

  logic              o_pc_wren;
  logic              o_ifid_wren;
  logic              o_ifid_clear;
  logic              o_idex_wren;
  logic              o_idex_clear;
  logic              o_exmem_wren;
  logic              o_exmem_clear;
  logic              o_memwb_clear;
  fwd_sel_e          o_fwd_a;
  fwd_sel_e          o_fwd_b;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;
  logic              o_lsu_timeout;

  modport master (
    output i_ifid_rs1, i_ifid_rs2, i_ifid_rs1_used, i_ifid_rs2_used,
           i_idex_rd, i_idex_rdwren, i_idex_is_load,
           i_exmem_rd, i_exmem_rdwren, i_memwb_rd, i_memwb_rdwren,
           i_exmem_redirect, i_lsu_busy,
    input  o_pc_wren, o_ifid_wren, o_ifid_clear, o_idex_wren, o_idex_clear,
           o_exmem_wren, o_exmem_clear, o_memwb_clear, o_fwd_a, o_fwd_b,
           o_stall_cnt, o_flush_cnt, o_lsu_timeout
  );

  modport slave (
    input  i_ifid_rs1, i_ifid_rs2, i_ifid_rs1_used, i_ifid_rs2_used,
           i_idex_rd, i_idex_rdwren, i_idex_is_load,
           i_exmem_rd, i_exmem_rdwren, i_memwb_rd, i_memwb_rdwren,
           i_exmem_redirect, i_lsu_busy,
    output o_pc_wren, o_ifid_wren, o_ifid_clear, o_idex_wren, o_idex_clear,
           o_exmem_wren, o_exmem_clear, o_memwb_clear, o_fwd_a, o_fwd_b,
           o_stall_cnt, o_flush_cnt, o_lsu_timeout
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; sync active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze and forwarding control for the 5-stage RV32I pipeline,
// with saturating perf counters and a sticky LSU-timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_EN      = 0,
  parameter int unsigned RF_WR_FIRST = 1,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT - 1);

  hz_state_e         state;
  logic [BUSY_W-1:0] busy_cnt;
  logic              lsu_timeout;

  logic raw_idex, raw_exmem, raw_memwb;
  logic data_stall, freeze, stall_evt, flush_evt;

  function automatic logic src_hit(logic wren, logic [REG_AW-1:0] rd,
                                   logic [REG_AW-1:0] rs, logic used);
    return wren && (rd != '0) && used && (rd == rs);
  endfunction

  always_comb begin
    raw_idex  = src_hit(hz.i_idex_rdwren, hz.i_idex_rd, hz.i_ifid_rs1, hz.i_ifid_rs1_used)
              | src_hit(hz.i_idex_rdwren, hz.i_idex_rd, hz.i_ifid_rs2, hz.i_ifid_rs2_used);
    raw_exmem = src_hit(hz.i_exmem_rdwren, hz.i_exmem_rd, hz.i_ifid_rs1, hz.i_ifid_rs1_used)
              | src_hit(hz.i_exmem_rdwren, hz.i_exmem_rd, hz.i_ifid_rs2, hz.i_ifid_rs2_used);
    raw_memwb = src_hit(hz.i_memwb_rdwren, hz.i_memwb_rd, hz.i_ifid_rs1, hz.i_ifid_rs1_used)
              | src_hit(hz.i_memwb_rdwren, hz.i_memwb_rd, hz.i_ifid_rs2, hz.i_ifid_rs2_used);

    if (FWD_EN != 0) begin
      data_stall = raw_idex && hz.i_idex_is_load;
    end else begin
      data_stall = raw_idex || raw_exmem || ((RF_WR_FIRST == 0) && raw_memwb);
    end

    // Freeze depends only on the live busy input, so outputs are state-independent
    // and naturally follow the RUN rules while reset is held.
    freeze    = hz.i_lsu_busy;
    flush_evt = !freeze && hz.i_exmem_redirect;
    stall_evt = freeze || (!hz.i_exmem_redirect && data_stall);
  end

  always_comb begin
    hz.o_pc_wren     = 1'b1;
    hz.o_ifid_wren   = 1'b1;
    hz.o_ifid_clear  = 1'b0;
    hz.o_idex_wren   = 1'b1;
    hz.o_idex_clear  = 1'b0;
    hz.o_exmem_wren  = 1'b1;
    hz.o_exmem_clear = 1'b0;
    hz.o_memwb_clear = 1'b0;
    if (freeze) begin
      hz.o_pc_wren     = 1'b0;
      hz.o_ifid_wren   = 1'b0;
      hz.o_idex_wren   = 1'b0;
      hz.o_exmem_wren  = 1'b0;
      hz.o_memwb_clear = 1'b1;
    end else if (hz.i_exmem_redirect) begin
      hz.o_ifid_clear  = 1'b1;
      hz.o_idex_clear  = 1'b1;
      hz.o_exmem_clear = 1'b1;
    end else if (data_stall) begin
      hz.o_pc_wren     = 1'b0;
      hz.o_ifid_wren   = 1'b0;
      hz.o_idex_clear  = 1'b1;
    end
  end

  always_comb begin
    hz.o_fwd_a = FWD_RF;
    hz.o_fwd_b = FWD_RF;
    if (FWD_EN != 0) begin
      hz.o_fwd_a = fwd_pick(
        src_hit(hz.i_exmem_rdwren, hz.i_exmem_rd, hz.i_ifid_rs1, hz.i_ifid_rs1_used),
        src_hit(hz.i_memwb_rdwren, hz.i_memwb_rd, hz.i_ifid_rs1, hz.i_ifid_rs1_used));
      hz.o_fwd_b = fwd_pick(
        src_hit(hz.i_exmem_rdwren, hz.i_exmem_rd, hz.i_ifid_rs2, hz.i_ifid_rs2_used),
        src_hit(hz.i_memwb_rdwren, hz.i_memwb_rd, hz.i_ifid_rs2, hz.i_ifid_rs2_used));
    end
  end

  // busy_cnt counts MEMWAIT cycles already elapsed, so the flag rises at the
  // end of the TIMEOUT-th consecutive MEMWAIT cycle that is still busy.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= HZ_RUN;
      busy_cnt    <= '0;
      lsu_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_RUN: begin
          busy_cnt <= '0;
          if (hz.i_lsu_busy) state <= HZ_MEMWAIT;
        end
        HZ_MEMWAIT: begin
          if (busy_cnt != '1) busy_cnt <= busy_cnt + BUSY_W'(1);
          if (hz.i_lsu_busy && (busy_cnt >= BUSY_LAST)) lsu_timeout <= 1'b1;
          if (!hz.i_lsu_busy) state <= HZ_RUN;
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  assign hz.o_lsu_timeout = lsu_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (stall_evt),
    .q     (hz.o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (flush_evt),
    .q     (hz.o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two controller configurations driven by shared stimulus and checked every
// cycle against a rule-table model, plus directed literal scenarios.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, idex_rd, exmem_rd, memwb_rd;
  logic u1, u2, idex_w, idex_ld, exmem_w, memwb_w, redir, busy;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifa ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifb ();

  assign ifa.i_ifid_rs1 = rs1;        assign ifb.i_ifid_rs1 = rs1;
  assign ifa.i_ifid_rs2 = rs2;        assign ifb.i_ifid_rs2 = rs2;
  assign ifa.i_ifid_rs1_used = u1;    assign ifb.i_ifid_rs1_used = u1;
  assign ifa.i_ifid_rs2_used = u2;    assign ifb.i_ifid_rs2_used = u2;
  assign ifa.i_idex_rd = idex_rd;     assign ifb.i_idex_rd = idex_rd;
  assign ifa.i_idex_rdwren = idex_w;  assign ifb.i_idex_rdwren = idex_w;
  assign ifa.i_idex_is_load = idex_ld; assign ifb.i_idex_is_load = idex_ld;
  assign ifa.i_exmem_rd = exmem_rd;   assign ifb.i_exmem_rd = exmem_rd;
  assign ifa.i_exmem_rdwren = exmem_w; assign ifb.i_exmem_rdwren = exmem_w;
  assign ifa.i_memwb_rd = memwb_rd;   assign ifb.i_memwb_rd = memwb_rd;
  assign ifa.i_memwb_rdwren = memwb_w; assign ifb.i_memwb_rdwren = memwb_w;
  assign ifa.i_exmem_redirect = redir; assign ifb.i_exmem_redirect = redir;
  assign ifa.i_lsu_busy = busy;       assign ifb.i_lsu_busy = busy;

  hazard_ctrl #(.FWD_EN(0), .RF_WR_FIRST(0), .REG_AW(5), .CNT_W(4), .TIMEOUT(4)) dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .hz (ifa));
  hazard_ctrl #(.FWD_EN(1), .RF_WR_FIRST(1), .REG_AW(5), .CNT_W(16), .TIMEOUT(6)) dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .hz (ifb));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cmax [2] = '{15, 65535};
  int tmo  [2] = '{4, 6};
  int stall_m [2];
  int flush_m [2];
  bit flag_m  [2];
  int streak;

  function automatic bit dep(logic w, logic [4:0] rd, logic [4:0] rs, logic used);
    return w && rd != 0 && used && rd == rs;
  endfunction

  // 1 freeze, 2 redirect, 3 data stall, 4 normal
  function automatic int rule_of(int c);
    bit fwd = (c == 1);
    bit wrf = (c == 1);
    bit h_idex  = dep(idex_w, idex_rd, rs1, u1) || dep(idex_w, idex_rd, rs2, u2);
    bit h_exmem = dep(exmem_w, exmem_rd, rs1, u1) || dep(exmem_w, exmem_rd, rs2, u2);
    bit h_memwb = dep(memwb_w, memwb_rd, rs1, u1) || dep(memwb_w, memwb_rd, rs2, u2);
    bit st = fwd ? (h_idex && idex_ld) : (h_idex || h_exmem || (!wrf && h_memwb));
    if (busy) return 1;
    if (redir) return 2;
    if (st) return 3;
    return 4;
  endfunction

  function automatic logic [1:0] fwd_of(int c, logic [4:0] rs, logic used);
    if (c == 0) return 2'd0;
    if (dep(exmem_w, exmem_rd, rs, used)) return 2'd1;
    if (dep(memwb_w, memwb_rd, rs, used)) return 2'd2;
    return 2'd0;
  endfunction

  // {pc_w, ifid_w, ifid_c, idex_w, idex_c, exmem_w, exmem_c, memwb_c, fwd_a, fwd_b}
  function automatic logic [11:0] exp_ctrl(int c);
    logic [7:0] t;
    case (rule_of(c))
      1:       t = 8'b0000_0001;
      2:       t = 8'b1111_1110;
      3:       t = 8'b0001_1100;
      default: t = 8'b1101_0100;
    endcase
    return {t, fwd_of(c, rs1, u1), fwd_of(c, rs2, u2)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      streak <= 0;
      for (int c = 0; c < 2; c++) begin
        stall_m[c] <= 0; flush_m[c] <= 0; flag_m[c] <= 1'b0;
      end
    end else begin
      streak <= busy ? streak + 1 : 0;
      for (int c = 0; c < 2; c++) begin
        if ((rule_of(c) == 1 || rule_of(c) == 3) && stall_m[c] < cmax[c]) stall_m[c] <= stall_m[c] + 1;
        if (rule_of(c) == 2 && flush_m[c] < cmax[c]) flush_m[c] <= flush_m[c] + 1;
        if (busy && (streak + 1) >= tmo[c] + 1) flag_m[c] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl_a", {ifa.o_pc_wren, ifa.o_ifid_wren, ifa.o_ifid_clear, ifa.o_idex_wren,
                     ifa.o_idex_clear, ifa.o_exmem_wren, ifa.o_exmem_clear, ifa.o_memwb_clear,
                     ifa.o_fwd_a, ifa.o_fwd_b}, exp_ctrl(0));
      chk("ctrl_b", {ifb.o_pc_wren, ifb.o_ifid_wren, ifb.o_ifid_clear, ifb.o_idex_wren,
                     ifb.o_idex_clear, ifb.o_exmem_wren, ifb.o_exmem_clear, ifb.o_memwb_clear,
                     ifb.o_fwd_a, ifb.o_fwd_b}, exp_ctrl(1));
      chk("stall_a", ifa.o_stall_cnt, stall_m[0]);
      chk("stall_b", ifb.o_stall_cnt, stall_m[1]);
      chk("flush_a", ifa.o_flush_cnt, flush_m[0]);
      chk("flush_b", ifb.o_flush_cnt, flush_m[1]);
      chk("tmo_a", ifa.o_lsu_timeout, flag_m[0]);
      chk("tmo_b", ifb.o_lsu_timeout, flag_m[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_in();
    rs1 = 0; rs2 = 0; idex_rd = 0; exmem_rd = 0; memwb_rd = 0;
    u1 = 0; u2 = 0; idex_w = 0; idex_ld = 0; exmem_w = 0; memwb_w = 0;
    redir = 0; busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    clr_in();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  int burst_left;

  initial begin
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    sample();
    chk("rst_stall", ifa.o_stall_cnt, 0);
    chk("rst_flush", ifa.o_flush_cnt, 0);
    chk("rst_tmo", ifa.o_lsu_timeout, 0);
    chk("rst_pc", ifa.o_pc_wren, 1);

    // interlock on EX-stage producer
    next_cycle(); idex_rd = 5; idex_w = 1; rs1 = 5; u1 = 1;
    sample();
    chk("t1_pc", ifa.o_pc_wren, 0);
    chk("t1_ifid_w", ifa.o_ifid_wren, 0);
    chk("t1_idex_c", ifa.o_idex_clear, 1);
    chk("t1_b_pc", ifb.o_pc_wren, 1);
    next_cycle(); clr_in();
    sample();
    chk("t1_cnt", ifa.o_stall_cnt, 1);

    // x0 and unused sources
    next_cycle(); idex_rd = 0; idex_w = 1; rs1 = 0; u1 = 1;
    sample();
    chk("t2_x0", ifa.o_pc_wren, 1);
    next_cycle(); clr_in(); idex_rd = 5; idex_w = 1; rs2 = 5; u2 = 0;
    sample();
    chk("t2_unused", ifa.o_pc_wren, 1);

    // forwarding and load-use
    next_cycle(); clr_in(); exmem_rd = 7; exmem_w = 1; memwb_rd = 7; memwb_w = 1; rs2 = 7; u2 = 1;
    sample();
    chk("t3_fwd_b", ifb.o_fwd_b, 2'b01);
    chk("t3_a_fwd_b", ifa.o_fwd_b, 2'b00);
    next_cycle(); clr_in(); idex_rd = 7; idex_w = 1; idex_ld = 1; rs2 = 7; u2 = 1;
    sample();
    chk("t3_loaduse", ifb.o_pc_wren, 0);
    next_cycle(); idex_ld = 0;
    sample();
    chk("t3_noload", ifb.o_pc_wren, 1);

    // redirect beats data stall
    do_reset();
    idex_rd = 5; idex_w = 1; rs1 = 5; u1 = 1; redir = 1;
    sample();
    chk("t4_ifid_c", ifa.o_ifid_clear, 1);
    chk("t4_exmem_c", ifa.o_exmem_clear, 1);
    chk("t4_pc", ifa.o_pc_wren, 1);
    next_cycle(); clr_in();
    sample();
    chk("t4_flush", ifa.o_flush_cnt, 1);
    chk("t4_stall", ifa.o_stall_cnt, 0);

    // freeze holds a pending redirect
    do_reset();
    busy = 1; redir = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t5_memwb_c", ifa.o_memwb_clear, 1);
      chk("t5_ifid_c", ifa.o_ifid_clear, 0);
      next_cycle();
    end
    busy = 0;
    sample();
    chk("t5_redir", ifa.o_ifid_clear, 1);
    next_cycle(); clr_in();
    sample();
    chk("t5_stall", ifa.o_stall_cnt, 3);
    chk("t5_flush", ifa.o_flush_cnt, 1);

    // LSU timeout
    do_reset();
    busy = 1;
    for (int k = 1; k <= 10; k++) begin
      sample();
      chk("t6_tmo_a", ifa.o_lsu_timeout, (k >= 6) ? 1 : 0);
      chk("t6_tmo_b", ifb.o_lsu_timeout, (k >= 8) ? 1 : 0);
      next_cycle();
    end
    busy = 0;
    sample();
    chk("t6_sticky", ifa.o_lsu_timeout, 1);
    next_cycle(); busy = 1;
    next_cycle(); rst_n = 1'b0;
    sample();
    chk("t6_rst_freeze", ifa.o_memwb_clear, 1);
    next_cycle(); rst_n = 1'b1; busy = 0;
    sample();
    chk("t6_rst_stall", ifa.o_stall_cnt, 0);
    chk("t6_rst_tmo", ifa.o_lsu_timeout, 0);
    next_cycle(); busy = 1;
    for (int k = 1; k <= 5; k++) begin
      sample();
      chk("t6_restart", ifa.o_lsu_timeout, 0);
      next_cycle();
    end
    busy = 0;

    // saturation at CNT_W=4
    do_reset();
    idex_rd = 5; idex_w = 1; rs1 = 5; u1 = 1;
    repeat (20) next_cycle();
    clr_in();
    sample();
    chk("t7_sat", ifa.o_stall_cnt, 15);

    // randomized traffic
    burst_left = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3)); exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom);
      idex_w = 1'($urandom); idex_ld = 1'($urandom);
      exmem_w = 1'($urandom); memwb_w = 1'($urandom);
      redir = ($urandom_range(0, 4) == 0);
      if (burst_left > 0) begin
        busy = 1; burst_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        busy = 1; burst_left = $urandom_range(0, 11);
      end else begin
        busy = 0;
      end
      rst_n = ($urandom_range(0, 199) != 0);
    end

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
